mem_read_master: RTL and testbench
==================================

Name: mem_read_master

Overview:
- Memory-side read engine between the main control unit and the external pixel SRAM (Avalon-MM master).
- Accepts a one-cycle read-enable plus pixel index from the control unit and performs one bus read.
- Returns the 24-bit RGB pixel to the grayscale stage and pulses read-complete back to the control unit.
- Guarantees a completion pulse for every accepted request, including on bus timeout, so the control unit never hangs in its read-wait state.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of pixel index 0 on the bus.
- TIMEOUT, 1023, maximum cycles spent in REQ plus WAIT_DATA before the read is aborted; must be ≥ 2.
- CNT_W, 10, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk, in, 1, system clock; all logic is on the rising edge.
- rst, in, 1, synchronous active-high reset.
- i_re, in, 1, read request; one-cycle pulse from the control unit.
- i_raddr, in, 32, pixel index; sampled only in the cycle i_re=1 is accepted.
- o_read_complete, out, 1, one-cycle pulse; o_pixel is valid in the same cycle.
- o_pixel, out, 24, captured pixel {R[23:16], G[15:8], B[7:0]}; held until the next completion.
- o_busy, out, 1, high from the cycle after acceptance through the DONE/ERR cycle.
- o_err_code, out, 2, sticky error flags: bit0 = timeout, bit1 = i_re received while busy.
- avm_address, out, 32, bus byte address.
- avm_read, out, 1, bus read strobe.
- avm_waitrequest, in, 1, slave stall; the request is accepted in a cycle with avm_read=1 and avm_waitrequest=0.
- avm_readdata, in, 32, read data; bits [31:24] are ignored.
- avm_readdatavalid, in, 1, marks avm_readdata valid.

Behaviour:
- All outputs are registered.
- Reset values: o_read_complete=0, o_pixel=0, o_busy=0, o_err_code=0, avm_read=0, avm_address=BASE_ADDR, state=IDLE, timeout counter=0.
- Address arithmetic: avm_address = BASE_ADDR + (i_raddr << 2), computed modulo 2^32; overflow wraps silently.
- State IDLE:
  - On i_re=1: latch avm_address, set avm_read=1 and o_busy=1, go to REQ.
  - avm_readdatavalid in IDLE is ignored; o_pixel is unchanged.
- State REQ:
  - avm_read and avm_address are held stable while avm_waitrequest=1.
  - On acceptance: avm_read=0 on the next cycle.
  - If avm_readdatavalid=1 in the acceptance cycle: capture the data and go to DONE.
  - Otherwise go to WAIT_DATA.
- State WAIT_DATA: on avm_readdatavalid=1, o_pixel <= avm_readdata[23:0] and go to DONE.
- State DONE:
  - o_read_complete=1 for exactly this cycle; o_busy=1.
  - Next state is IDLE, where o_busy=0.
- Timeout counter:
  - Cleared on entry to REQ; increments every cycle spent in REQ or WAIT_DATA.
  - When the counter reaches TIMEOUT and data has not been captured: avm_read=0, o_pixel <= 0, o_err_code[0] <= 1, go to ERR.
- State ERR: o_read_complete=1 for one cycle (same timing as DONE), then IDLE.
- Completion timing: i_re sampled at cycle 0; avm_read=1 at cycle 1. With zero wait states and readdatavalid at cycle 1+L (L≥0), o_read_complete=1 at cycle 2+L.
- Simultaneous events:
  - Data arriving in the same cycle the counter reaches TIMEOUT: data wins; normal DONE; no error.
  - i_re=1 in any state other than IDLE: request dropped, o_err_code[1] <= 1, no other effect.
  - i_re=1 in the DONE/ERR cycle is also dropped and flagged.
- Stray data: avm_readdatavalid arriving after ERR (a late response) is ignored in IDLE. If it arrives while a new request is in REQ before acceptance, it is ignored. Only data in or after the acceptance cycle is captured.
- o_err_code is cleared only by rst.
- Reset mid-operation: rst in any state returns every output to its reset value on the next edge. avm_read drops immediately at that edge. No completion pulse is produced for the aborted request.

Test Plan:
- Basic read: rst released; i_re=1 with i_raddr=5, BASE_ADDR=0; waitrequest=0; readdatavalid 2 cycles after acceptance with readdata=32'hAA112233.
  -> avm_address=20 and avm_read=1 for exactly 1 cycle; o_pixel=24'h112233; o_read_complete at cycle 4; o_err_code=0.
- Wait states: waitrequest=1 for 3 cycles, then 0; data latency 0 (same cycle).
  -> avm_read high 4 cycles with address stable throughout; a single o_read_complete pulse; pixel captured.
- Timeout: TIMEOUT=8; slave never returns readdatavalid.
  -> ERR 8 cycles after REQ entry; o_read_complete pulses; o_pixel=0; o_err_code=2'b01 persists through later successful reads.
- Busy overrun: second i_re issued while in WAIT_DATA.
  -> no second bus read; o_err_code[1]=1; exactly one completion pulse.
- Wrap and stray data: BASE_ADDR=32'hFFFF_FFF0, i_raddr=8, giving address 32'h0000_0010; plus readdatavalid pulsed in IDLE.
  -> o_pixel is unchanged by the stray pulse and no completion is generated.
- Reset mid-read: rst asserted while in REQ with avm_read=1.
  -> next cycle avm_read=0, o_busy=0, o_err_code=0; no o_read_complete; a fresh i_re completes normally.

Source files
------------

// File: rtl/mem_read_master.sv
`default_nettype none
//==============================================================================
// Module   : mem_read_master
// Purpose  : Single-beat Avalon-MM read engine that fetches one 24-bit RGB
//            pixel per request from the pixel SRAM. Every accepted request
//            produces exactly one completion pulse, including on bus timeout.
// Revision : 1.0  initial release
//==============================================================================
module mem_read_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,  // byte address of pixel 0
    parameter int          TIMEOUT   = 1023,           // max cycles in REQ+WAIT_DATA (>= 2)
    parameter int          CNT_W     = 10              // 2**CNT_W must exceed TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    // control unit side
    input  logic        i_re,
    input  logic [31:0] i_raddr,
    output logic        o_read_complete,
    output logic [23:0] o_pixel,
    output logic        o_busy,
    output logic [1:0]  o_err_code,
    // Avalon-MM master
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_REQ       = 3'd1;
    localparam logic [2:0] c_S_WAIT_DATA = 3'd2;
    localparam logic [2:0] c_S_DONE      = 3'd3;
    localparam logic [2:0] c_S_ERR       = 3'd4;

    // Counter value seen in the last cycle allowed in REQ/WAIT_DATA. The
    // counter is zero in the first REQ cycle, so TIMEOUT cycles elapse when
    // it shows TIMEOUT-1 and the transition into ERR happens on that edge.
    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT - 1);

    // state and registered outputs
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_read_complete;
    logic [23:0]      r_pixel;
    logic             r_busy;
    logic [1:0]       r_err_code;
    logic [31:0]      r_avm_address;
    logic             r_avm_read;

    // next-value wires
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_read_complete_nxt;
    logic [23:0]      w_pixel_nxt;
    logic             w_busy_nxt;
    logic [1:0]       w_err_code_nxt;
    logic [31:0]      w_avm_address_nxt;
    logic             w_avm_read_nxt;

    logic             w_accept;       // slave takes the read this cycle
    logic             w_timeout_hit;  // this is the final permitted cycle
    logic             w_busy_req;     // request arriving while not idle
    logic             w_unused;

    assign w_accept      = r_avm_read & ~avm_waitrequest;
    assign w_timeout_hit = (r_cnt == c_TO_LAST);
    assign w_busy_req    = i_re & (r_state != c_S_IDLE);
    // Alpha/padding byte of the bus word carries no pixel information.
    assign w_unused      = ^avm_readdata[31:24];

    // State register plus registered outputs; reset aborts any read silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_S_IDLE;
            r_cnt           <= '0;
            r_read_complete <= 1'b0;
            r_pixel         <= '0;
            r_busy          <= 1'b0;
            r_err_code      <= '0;
            r_avm_address   <= BASE_ADDR;
            r_avm_read      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_read_complete <= w_read_complete_nxt;
            r_pixel         <= w_pixel_nxt;
            r_busy          <= w_busy_nxt;
            r_err_code      <= w_err_code_nxt;
            r_avm_address   <= w_avm_address_nxt;
            r_avm_read      <= w_avm_read_nxt;
        end
    end

    // Next-state logic; data arriving on the final cycle beats the timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (i_re) begin
                    w_state_nxt = c_S_REQ;
                end
            end
            c_S_REQ: begin
                if (w_accept && avm_readdatavalid) begin
                    w_state_nxt = c_S_DONE;
                end else if (w_timeout_hit) begin
                    w_state_nxt = c_S_ERR;
                end else if (w_accept) begin
                    w_state_nxt = c_S_WAIT_DATA;
                end
            end
            c_S_WAIT_DATA: begin
                if (avm_readdatavalid) begin
                    w_state_nxt = c_S_DONE;
                end else if (w_timeout_hit) begin
                    w_state_nxt = c_S_ERR;
                end
            end
            c_S_DONE: w_state_nxt = c_S_IDLE;
            c_S_ERR:  w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // Output/datapath next values, all derived from the current and next state.
    always_comb begin
        w_cnt_nxt           = r_cnt;
        w_pixel_nxt         = r_pixel;
        w_avm_address_nxt   = r_avm_address;
        w_err_code_nxt      = r_err_code;
        w_avm_read_nxt      = (w_state_nxt == c_S_REQ);
        w_busy_nxt          = (w_state_nxt != c_S_IDLE);
        w_read_complete_nxt = (w_state_nxt == c_S_DONE) || (w_state_nxt == c_S_ERR);

        if (r_state == c_S_IDLE) begin
            if (i_re) begin
                // Word-per-pixel layout; wraps modulo 2**32 by construction.
                w_avm_address_nxt = BASE_ADDR + (i_raddr << 2);
                w_cnt_nxt         = '0;
            end
        end else if ((r_state == c_S_REQ) || (r_state == c_S_WAIT_DATA)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end

        if (((r_state == c_S_REQ) || (r_state == c_S_WAIT_DATA)) &&
            (w_state_nxt == c_S_DONE)) begin
            w_pixel_nxt = avm_readdata[23:0];
        end else if (w_state_nxt == c_S_ERR) begin
            w_pixel_nxt = '0;
        end

        if (w_state_nxt == c_S_ERR) begin
            w_err_code_nxt[0] = 1'b1;
        end
        if (w_busy_req) begin
            w_err_code_nxt[1] = 1'b1;
        end
    end

    assign o_read_complete = r_read_complete;
    assign o_pixel         = r_pixel;
    assign o_busy          = r_busy;
    assign o_err_code      = r_err_code;
    assign avm_address     = r_avm_address;
    assign avm_read        = r_avm_read;

endmodule
`default_nettype wire

// File: tb/tb_mem_read_master.sv
`default_nettype none
//==============================================================================
// Module   : tb_mem_read_master
// Purpose  : Randomized scoreboard bench for mem_read_master with a
//            transaction-level slave and reference model.
// Revision : 1.0  initial release
//==============================================================================
module tb_mem_read_master;

    localparam logic [31:0] c_BASE    = 32'hFFFF_FFF0;
    localparam int          c_TIMEOUT = 8;
    localparam int          c_CNT_W   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_re;
    logic [31:0] i_raddr;
    logic        o_read_complete;
    logic [23:0] o_pixel;
    logic        o_busy;
    logic [1:0]  o_err_code;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    mem_read_master #(
        .BASE_ADDR (c_BASE),
        .TIMEOUT   (c_TIMEOUT),
        .CNT_W     (c_CNT_W)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .i_re              (i_re),
        .i_raddr           (i_raddr),
        .o_read_complete   (o_read_complete),
        .o_pixel           (o_pixel),
        .o_busy            (o_busy),
        .o_err_code        (o_err_code),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    int          total = 0;
    int          bad = 0;
    logic [23:0] exp_pix_q[$];
    int          exp_cyc_q[$];
    logic [31:0] exp_addr = '0;
    logic [1:0]  exp_err = '0;
    logic [23:0] last_pix = '0;
    int          accept_exp = 0;
    int          accept_seen = 0;
    logic [23:0] mon_p;
    int          mon_c;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: bus address stability/acceptances and completion scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (avm_read) chk("avm_address", 64'(avm_address), 64'(exp_addr));
            if (avm_read && !avm_waitrequest) accept_seen++;
            if (o_read_complete) begin
                if (exp_pix_q.size() == 0) begin
                    chk("spurious_completion", 64'(1), 64'(0));
                end else begin
                    mon_p = exp_pix_q.pop_front();
                    mon_c = exp_cyc_q.pop_front();
                    chk("pixel", 64'(o_pixel), 64'(mon_p));
                    chk("completion_cycle", 64'(cyc), 64'(mon_c));
                    chk("err_at_completion", 64'(o_err_code), 64'(exp_err));
                    chk("busy_at_completion", 64'(o_busy), 64'(1));
                end
            end
        end
    end

    // mode 0: data returned; 1: accepted but no data; 2: never accepted
    task automatic run_txn(input logic [31:0] idx, input logic [31:0] data, input int ws,
                           input int lat, input int mode, input bit ovr, input bit ovr_done);
        int c0;
        bit got;
        @(posedge clk); #1;
        c0 = cyc;
        i_re     = 1'b1;
        i_raddr  = idx;
        exp_addr = c_BASE + (idx * 32'd4);
        if (mode != 2) accept_exp++;
        if (mode == 0) begin
            exp_pix_q.push_back(data[23:0]);
            exp_cyc_q.push_back(c0 + 2 + ws + lat);
            last_pix = data[23:0];
        end else begin
            exp_pix_q.push_back(24'h0);
            exp_cyc_q.push_back(c0 + 1 + c_TIMEOUT);
            last_pix = 24'h0;
            exp_err[0] = 1'b1;
        end
        @(posedge clk); #1;
        i_re = 1'b0;
        if (mode == 2) begin
            avm_waitrequest = 1'b1;
        end else begin
            for (int k = 0; k < ws; k++) begin
                avm_waitrequest   = 1'b1;
                avm_readdatavalid = 1'($urandom_range(0, 1));
                avm_readdata      = $urandom;
                @(posedge clk); #1;
            end
            avm_waitrequest   = 1'b0;
            avm_readdatavalid = (mode == 0) && (lat == 0);
            avm_readdata      = avm_readdatavalid ? data : $urandom;
            for (int j = 1; j <= lat; j++) begin
                @(posedge clk); #1;
                avm_waitrequest   = 1'($urandom_range(0, 1));
                avm_readdatavalid = (mode == 0) && (j == lat);
                avm_readdata      = avm_readdatavalid ? data : $urandom;
                i_re              = ovr && (j == 1);
                if (ovr && j == 1) exp_err[1] = 1'b1;
            end
            @(posedge clk); #1;
            avm_readdatavalid = 1'b0;
            i_re = 1'b0;
        end
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (o_read_complete) got = 1'b1;
            else if (mode == 2) avm_readdatavalid = 1'($urandom_range(0, 1));
        end
        if (!got) chk("completion_timeout", 64'(0), 64'(1));
        if (ovr_done) begin
            i_re = 1'b1;
            exp_err[1] = 1'b1;
        end
        @(posedge clk); #1;
        i_re = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        chk("busy_after", 64'(o_busy), 64'(0));
        chk("err_after", 64'(o_err_code), 64'(exp_err));
    endtask

    task automatic stray_idle();
        @(posedge clk); #1;
        avm_readdatavalid = 1'b1;
        avm_readdata = $urandom;
        @(posedge clk); #1;
        avm_readdatavalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_pixel_hold", 64'(o_pixel), 64'(last_pix));
        chk("stray_no_completion", 64'(o_read_complete), 64'(0));
    endtask

    task automatic reset_mid();
        @(posedge clk); #1;
        i_re = 1'b1;
        i_raddr = 32'd4;
        exp_addr = c_BASE + 32'd16;
        @(posedge clk); #1;
        i_re = 1'b0;
        avm_waitrequest = 1'b1;
        @(negedge clk);
        chk("mid_read_active", 64'(avm_read), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_err = '0;
        last_pix = '0;
        @(negedge clk);
        chk("rst_avm_read", 64'(avm_read), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_err", 64'(o_err_code), 64'(0));
        chk("rst_cplt", 64'(o_read_complete), 64'(0));
        avm_waitrequest = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_pixel", 64'(o_pixel), 64'(0));
    endtask

    initial begin
        int ws;
        int lat;
        int mode;
        rst = 1'b1;
        i_re = 1'b0;
        i_raddr = '0;
        avm_waitrequest = 1'b0;
        avm_readdata = '0;
        avm_readdatavalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_cplt", 64'(o_read_complete), 64'(0));
        chk("reset_pixel", 64'(o_pixel), 64'(0));
        chk("reset_busy", 64'(o_busy), 64'(0));
        chk("reset_err", 64'(o_err_code), 64'(0));
        chk("reset_read", 64'(avm_read), 64'(0));
        chk("reset_addr", 64'(avm_address), 64'(c_BASE));

        run_txn(32'd5, 32'hAA11_2233, 0, 2, 0, 1'b0, 1'b0);  // basic read
        run_txn(32'd8, 32'h00C0_FFEE, 3, 0, 0, 1'b0, 1'b0);  // wrapped address 0x10, stalls
        run_txn(32'd3, 32'h1234_5678, 3, 4, 0, 1'b0, 1'b0);  // data on final permitted cycle
        run_txn(32'd7, 32'h0, 0, 0, 1, 1'b0, 1'b0);          // accepted, no data
        stray_idle();                                         // late response after ERR
        run_txn(32'd9, 32'h55AA_BBCC, 1, 3, 0, 1'b1, 1'b0);  // overrun in WAIT_DATA
        run_txn(32'd2, 32'h0, 0, 0, 2, 1'b0, 1'b1);          // never accepted, i_re in ERR
        reset_mid();
        run_txn(32'd1, 32'h0077_8899, 0, 0, 0, 1'b0, 1'b0);  // fresh read after reset

        for (int t = 0; t < 40; t++) begin
            ws   = $urandom_range(0, 3);
            lat  = $urandom_range(0, 4);
            mode = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_txn($urandom, $urandom, ws, lat, mode,
                    (mode == 0) && (lat > 0) && ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 5) == 0) stray_idle();
        end
        stray_idle();
        chk("bus_accept_count", 64'(accept_seen), 64'(accept_exp));
        chk("scoreboard_empty", 64'(exp_pix_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
